// File: rtl/watchdog_pkg.sv
// Shared types and default constants for the sequential fixed-point divider.
package watchdog_pkg;

  localparam int unsigned W_DEF       = 32;
  localparam int unsigned F_DEF       = 16;
  localparam int unsigned TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_MUL   = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK   = 2'd0,
    ERR_DIV0 = 2'd1,
    ERR_RCP  = 2'd2,
    ERR_TMO  = 2'd3
  } err_t;

endpackage

// File: rtl/fx_mul_sat.sv
// Combinational QF multiply of a signed numerator by an unsigned reciprocal,
// with arithmetic rescale, optional negation and saturation to W bits.
module fx_mul_sat
  import watchdog_pkg::*;
#(
  parameter int unsigned W = W_DEF,
  parameter int unsigned F = F_DEF
) (
  input  logic signed [W-1:0] num,
  input  logic        [W-1:0] inv,
  input  logic                neg,
  output logic signed [W-1:0] quot_c,
  output logic                sat_c
);

  localparam int unsigned PW = 2 * W + 1;
  localparam int unsigned PV = PW + 1;
  // One extra bit over the product so negating the most negative value cannot wrap.
  localparam logic signed [PV-1:0] MAX_V = {{(PV - W + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [PV-1:0] MIN_V = {{(PV - W + 1){1'b1}}, {(W - 1){1'b0}}};
  localparam logic        [W-1:0]  MAX_Q = {1'b0, {(W - 1){1'b1}}};
  localparam logic        [W-1:0]  MIN_Q = {1'b1, {(W - 1){1'b0}}};

  logic signed [PW-1:0] op_a;
  logic signed [PW-1:0] op_b;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] scaled;
  logic signed [PV-1:0] val;

  always_comb begin
    op_a   = PW'(num);
    op_b   = PW'($signed({1'b0, inv}));
    prod   = op_a * op_b;
    scaled = prod >>> F;
    val    = neg ? -PV'(scaled) : PV'(scaled);
    quot_c = val[W-1:0];
    sat_c  = 1'b0;
    if (val > MAX_V) begin
      quot_c = MAX_Q;
      sat_c  = 1'b1;
    end else if (val < MIN_V) begin
      quot_c = MIN_Q;
      sat_c  = 1'b1;
    end
  end

endmodule

// File: rtl/fx_div_seq.sv
// Sequential QF divider: num/den computed as num * (1/|den|) using an external
// reciprocal unit on the rc_* handshake, with DIV0, invalid and timeout reporting.
module fx_div_seq
  import watchdog_pkg::*;
#(
  parameter int unsigned W       = W_DEF,
  parameter int unsigned F       = F_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic signed [W-1:0] num,
  input  logic signed [W-1:0] den,
  output logic                res_valid,
  input  logic                res_ready,
  output logic signed [W-1:0] quot,
  output logic        [1:0]   res_err,
  output logic                res_sat,
  output logic                rc_start,
  output logic signed [W-1:0] rc_x,
  input  logic                rc_done,
  input  logic        [W-1:0] rc_inv,
  input  logic                rc_invalid
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  // The ISSUE cycle counts toward the budget, so WAIT gives up one count early.
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 2);

  state_t               state;
  logic        [CW-1:0] cnt;
  logic signed [W-1:0]  num_q;
  logic        [W-1:0]  inv_q;
  logic                 neg_q;
  logic signed [W-1:0]  mul_quot_c;
  logic                 mul_sat_c;
  logic                 den_zero_c;
  logic                 den_min_c;

  assign den_zero_c = (den == '0);
  assign den_min_c  = den[W-1] && (den[W-2:0] == '0);

  fx_mul_sat #(.W(W), .F(F)) u_mul (
    .num    (num_q),
    .inv    (inv_q),
    .neg    (neg_q),
    .quot_c (mul_quot_c),
    .sat_c  (mul_sat_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_ready <= 1'b0;
      res_valid <= 1'b0;
      quot      <= '0;
      res_err   <= ERR_OK;
      res_sat   <= 1'b0;
      rc_start  <= 1'b0;
      rc_x      <= '0;
      cnt       <= '0;
      num_q     <= '0;
      inv_q     <= '0;
      neg_q     <= 1'b0;
    end else begin
      rc_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_ready && req_valid) begin
            req_ready <= 1'b0;
            num_q     <= num;
            neg_q     <= den[W-1];
            if (den_zero_c || den_min_c) begin
              state     <= S_OUT;
              res_valid <= 1'b1;
              quot      <= '0;
              res_err   <= ERR_DIV0;
              res_sat   <= 1'b0;
            end else begin
              state    <= S_ISSUE;
              rc_start <= 1'b1;
              rc_x     <= den[W-1] ? -den : den;
              cnt      <= '0;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end

        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (rc_done) begin
            rc_x <= '0;
            if (rc_invalid) begin
              state     <= S_OUT;
              res_valid <= 1'b1;
              quot      <= '0;
              res_err   <= ERR_RCP;
              res_sat   <= 1'b0;
            end else begin
              inv_q <= rc_inv;
              state <= S_MUL;
            end
          end else if (cnt == TMO_LAST) begin
            rc_x      <= '0;
            state     <= S_OUT;
            res_valid <= 1'b1;
            quot      <= '0;
            res_err   <= ERR_TMO;
            res_sat   <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_MUL: begin
          quot      <= mul_quot_c;
          res_sat   <= mul_sat_c;
          res_err   <= ERR_OK;
          res_valid <= 1'b1;
          state     <= S_OUT;
        end

        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b0;
          res_valid <= 1'b0;
          rc_x      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fx_div_seq.sv
// Directed self-checking bench for fx_div_seq with a behavioural reciprocal responder.
module tb_fx_div_seq;

  localparam int unsigned W       = 32;
  localparam int unsigned F       = 16;
  localparam int unsigned TIMEOUT = 64;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic signed [W-1:0] num = '0;
  logic signed [W-1:0] den = '0;
  logic                res_valid;
  logic                res_ready = 1'b0;
  logic signed [W-1:0] quot;
  logic        [1:0]   res_err;
  logic                res_sat;
  logic                rc_start;
  logic signed [W-1:0] rc_x;
  logic                rc_done = 1'b0;
  logic        [W-1:0] rc_inv = '0;
  logic                rc_invalid = 1'b0;

  int checks = 0;
  int passes = 0;
  int starts = 0;
  int rsp_delay = 5;
  logic         rsp_inval = 1'b0;
  logic [W-1:0] rsp_inv_v = '0;
  logic [W-1:0] rcx_issue;
  int lat;

  fx_div_seq #(.W(W), .F(F), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .num        (num),
    .den        (den),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .quot       (quot),
    .res_err    (res_err),
    .res_sat    (res_sat),
    .rc_start   (rc_start),
    .rc_x       (rc_x),
    .rc_done    (rc_done),
    .rc_inv     (rc_inv),
    .rc_invalid (rc_invalid)
  );

  always #5 clk = ~clk;

  // Reciprocal responder: rc_done rises rsp_delay cycles after rc_start rises.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rc_start) begin
        starts++;
        repeat (rsp_delay) @(posedge clk);
        #1;
        rc_done    = 1'b1;
        rc_inv     = rsp_inv_v;
        rc_invalid = rsp_inval;
        @(posedge clk);
        #1;
        rc_done    = 1'b0;
        rc_invalid = 1'b0;
        rc_inv     = '0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present one request, wait for acceptance, then count cycles until res_valid is sampled.
  task automatic run(input logic [W-1:0] n, input logic [W-1:0] d, input logic [W-1:0] inv,
                     input logic inval, input int dly);
    int k;
    rsp_inv_v = inv;
    rsp_inval = inval;
    rsp_delay = dly;
    num       = n;
    den       = d;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin
      tick();
      k++;
    end
    tick();
    req_valid = 1'b0;
    rcx_issue = rc_x;
    lat = 1;
    while (!res_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    int s0;
    int seen;
    logic stable;
    logic rdy_seen;
    logic [W-1:0] held_q;

    // Reset state
    tick();
    tick();
    check("rst_res_valid", W'(res_valid), 32'd0);
    check("rst_quot", quot, 32'd0);
    check("rst_res_err", W'(res_err), 32'd0);
    check("rst_rc_start", W'(rc_start), 32'd0);
    check("rst_rc_x", rc_x, 32'd0);
    check("rst_req_ready", W'(req_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_req_ready", W'(req_ready), 32'd1);

    // 3.0 / 2.0 with reciprocal 0.5 after 5 cycles
    s0 = starts;
    run(32'h0003_0000, 32'h0002_0000, 32'h0000_8000, 1'b0, 5);
    check("t1_rc_x", rcx_issue, 32'h0002_0000);
    check("t1_latency", W'(lat), 32'd8);
    check("t1_quot", quot, 32'h0001_8000);
    check("t1_err", W'(res_err), 32'd0);
    check("t1_sat", W'(res_sat), 32'd0);
    consume();
    check("t1_starts", W'(starts - s0), 32'd1);
    check("t1_rc_x_idle", rc_x, 32'd0);

    // 1.0 / -4.0
    run(32'h0001_0000, 32'hFFFC_0000, 32'h0000_4000, 1'b0, 3);
    check("t2_rc_x", rcx_issue, 32'h0004_0000);
    check("t2_latency", W'(lat), 32'd6);
    check("t2_quot", quot, 32'hFFFF_C000);
    check("t2_err", W'(res_err), 32'd0);
    consume();

    // Zero and most-negative denominators never reach the reciprocal unit
    s0 = starts;
    run(32'h0001_0000, 32'h0000_0000, 32'h0, 1'b0, 3);
    check("div0_latency", W'(lat), 32'd1);
    check("div0_err", W'(res_err), 32'd1);
    check("div0_quot", quot, 32'd0);
    consume();
    run(32'h0001_0000, 32'h8000_0000, 32'h0, 1'b0, 3);
    check("dmin_err", W'(res_err), 32'd1);
    check("dmin_quot", quot, 32'd0);
    consume();
    tick();
    check("div0_no_start", W'(starts - s0), 32'd0);

    // Saturation both ways
    run(32'h7FFF_0000, 32'h0000_1000, 32'h0010_0000, 1'b0, 2);
    check("satp_quot", quot, 32'h7FFF_FFFF);
    check("satp_sat", W'(res_sat), 32'd1);
    consume();
    run(32'h7FFF_0000, 32'hFFFF_F000, 32'h0010_0000, 1'b0, 2);
    check("satn_rc_x", rcx_issue, 32'h0000_1000);
    check("satn_quot", quot, 32'h8000_0000);
    check("satn_sat", W'(res_sat), 32'd1);
    consume();

    // Negative numerator, and the most negative representable quotient
    run(32'hFFFE_0000, 32'h0002_0000, 32'h0000_8000, 1'b0, 1);
    check("negn_quot", quot, 32'hFFFF_0000);
    consume();
    run(32'h8000_0000, 32'h0001_0000, 32'h0001_0000, 1'b0, 1);
    check("minq_quot", quot, 32'h8000_0000);
    check("minq_sat", W'(res_sat), 32'd0);
    consume();
    run(32'h8000_0000, 32'hFFFF_0000, 32'h0001_0000, 1'b0, 1);
    check("minneg_quot", quot, 32'h7FFF_FFFF);
    check("minneg_sat", W'(res_sat), 32'd1);
    consume();

    // Reciprocal unit reports invalid operand
    run(32'h0001_0000, 32'h0000_0100, 32'h1234_5678, 1'b1, 2);
    check("rcp_err", W'(res_err), 32'd2);
    check("rcp_quot", quot, 32'd0);
    consume();

    // Timeout, then a late rc_done that must be ignored
    run(32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 1'b0, 70);
    check("tmo_latency", W'(lat), W'(TIMEOUT + 1));
    check("tmo_err", W'(res_err), 32'd3);
    check("tmo_quot", quot, 32'd0);
    consume();
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (res_valid) seen++;
    end
    check("tmo_late_ignored", W'(seen), 32'd0);
    check("tmo_idle_ready", W'(req_ready), 32'd1);

    // Backpressure: result held, new request refused
    run(32'h0003_0000, 32'h0002_0000, 32'h0000_8000, 1'b0, 2);
    check("bp_latency", W'(lat), 32'd5);
    s0 = starts;
    held_q = quot;
    num = 32'h1111_0000;
    den = 32'h0001_0000;
    req_valid = 1'b1;
    stable = 1'b1;
    rdy_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!res_valid || quot !== held_q || res_err !== 2'd0 || res_sat !== 1'b0) stable = 1'b0;
      if (req_ready) rdy_seen = 1'b1;
    end
    check("bp_stable", W'(stable), 32'd1);
    check("bp_quot", quot, 32'h0001_8000);
    check("bp_req_ready", W'(rdy_seen), 32'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    req_valid = 1'b0;
    check("bp_release_ready", W'(req_ready), 32'd1);
    check("bp_release_valid", W'(res_valid), 32'd0);
    tick();
    check("bp_no_accept", W'(starts - s0), 32'd0);

    // Reset while waiting on the reciprocal unit
    rsp_delay = 10;
    rsp_inv_v = 32'h0000_8000;
    rsp_inval = 1'b0;
    num = 32'h0003_0000;
    den = 32'h0002_0000;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("wrst_valid", W'(res_valid), 32'd0);
    check("wrst_rc_x", rc_x, 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (res_valid) seen++;
    end
    check("wrst_no_result", W'(seen), 32'd0);
    check("wrst_ready", W'(req_ready), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
